// File: rtl/ram512_stream_loader.sv
// Bulk-transfer controller in front of a RAM512: streams words into consecutive RAM locations
// (load) or streams consecutive locations out through a registered valid/ready port (dump).
module ram512_stream_loader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_load,
  input  logic                    cmd_dump,
  input  logic [AW-1:0]           base,
  input  logic [AW:0]             len,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic signed [WIDTH-1:0] m_data,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        ram_in,
  output logic                    ram_load,
  output logic [AW-1:0]           ram_address,
  input  logic [WIDTH-1:0]        ram_out
);

  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] One   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLoad, StDump, StDone} state_e;

  state_e                  state_q;
  logic [AW-1:0]           ptr_q;
  logic [AW:0]             rem_q;
  logic                    m_valid_q;
  logic signed [WIDTH-1:0] m_data_q;

  logic          load_beat;
  logic          dump_cap;
  logic          out_free;
  logic [AW:0]   len_clamped;

  assign len_clamped = (len > Depth) ? Depth : len;
  assign load_beat   = (state_q == StLoad) && s_valid && (rem_q != '0);
  // Output register can take a new word when empty or being drained this cycle.
  assign out_free    = !m_valid_q || m_ready;
  assign dump_cap    = (state_q == StDump) && (rem_q != '0) && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_load || cmd_dump) begin
            ptr_q <= base;
            rem_q <= len_clamped;
            if (len == '0) begin
              state_q <= StDone;
            end else if (cmd_load) begin
              state_q <= StLoad;
            end else begin
              state_q <= StDump;
            end
          end
        end
        StLoad: begin
          if (load_beat) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - One;
            if (rem_q == One) begin
              state_q <= StDone;
            end
          end
        end
        StDump: begin
          if (dump_cap) begin
            m_data_q  <= ram_out;
            m_valid_q <= 1'b1;
            ptr_q     <= ptr_q + 1'b1;
            rem_q     <= rem_q - One;
          end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
          end
          if ((rem_q == '0) && out_free) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign s_ready     = (state_q == StLoad) && (rem_q != '0);
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign ram_load    = load_beat;
  assign ram_in      = load_beat ? s_data : '0;
  assign ram_address = ((state_q == StLoad) || (state_q == StDump)) ? ptr_q : '0;

endmodule
